// File: rtl/fp_class_arb.sv
// Round-robin shared FP decompose/classify front end: arbiter, capture stage, classify/output stage.
// Optional NaN statistics counter is built when FPCLASS_STATS_EN is defined.
module fp_class_arb #(
  parameter int FPWID = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ),
  localparam int EMSB = (FPWID == 128) ? 14 : (FPWID == 80) ? 14 : (FPWID == 64) ? 10 : 7,
  localparam int FMSB = (FPWID == 128) ? 111 : (FPWID == 80) ? 63 : (FPWID == 64) ? 51 : 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*FPWID-1:0] i,
  output logic [NREQ-1:0]       ack,
  output logic                  o_v,
  input  logic                  o_rdy,
`ifdef FPCLASS_STATS_EN
  input  logic                  cnt_clr,
  output logic [15:0]           nan_cnt,
`endif
  output logic [IDW-1:0]        o_id,
  output logic [9:0]            o_class,
  output logic                  o_sgn,
  output logic [EMSB:0]         o_exp,
  output logic [FMSB+1:0]       o_fract
);

  logic             s1_v_r;
  logic [IDW-1:0]   s1_id_r;
  logic [FPWID-1:0] s1_op_r;
  logic [IDW-1:0]   rr_r;

  logic             adv1_s;
  logic             adv2_s;
  logic             take_s;
  logic             gnt_v_s;
  logic [IDW-1:0]   gnt_s;
  logic [IDW-1:0]   cand_s;
  logic [FPWID-1:0] op_s;
  logic [EMSB:0]    s1_exp_s;
  logic [FMSB:0]    s1_man_s;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    if (v == IDW'(NREQ - 1)) begin
      wrap_inc = '0;
    end else begin
      wrap_inc = v + 1'b1;
    end
  endfunction

  // One-hot class: bits 0..7 are -inf..+inf by sign and magnitude, bit 8 sNaN, bit 9 qNaN.
  function automatic logic [9:0] fp_class(input logic sgn, input logic [EMSB:0] e,
                                          input logic [FMSB:0] m);
    logic xinf, xz, mz, qb;
    xinf = &e;
    xz   = ~|e;
    mz   = ~|m;
    qb   = m[FMSB];
    fp_class[0] =  sgn & xinf & mz;
    fp_class[1] =  sgn & !xz & !xinf;
    fp_class[2] =  sgn & xz & !mz;
    fp_class[3] =  sgn & xz & mz;
    fp_class[4] = !sgn & xz & mz;
    fp_class[5] = !sgn & xz & !mz;
    fp_class[6] = !sgn & !xz & !xinf;
    fp_class[7] = !sgn & xinf & mz;
    fp_class[8] =  xinf & !mz & !qb;
    fp_class[9] =  xinf & qb;
  endfunction

  assign adv2_s   = !o_v || o_rdy;
  assign adv1_s   = !s1_v_r || adv2_s;
  assign take_s   = !rst && adv1_s && gnt_v_s;
  assign s1_exp_s = s1_op_r[FPWID-2 -: EMSB+1];
  assign s1_man_s = s1_op_r[FMSB:0];

  // Round-robin search: first requesting index at or after the pointer, wrapping.
  always_comb begin
    gnt_v_s = 1'b0;
    gnt_s   = '0;
    cand_s  = rr_r;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_v_s && req[cand_s]) begin
        gnt_v_s = 1'b1;
        gnt_s   = cand_s;
      end else begin
        gnt_v_s = gnt_v_s;
      end
      cand_s = wrap_inc(cand_s);
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    op_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_s == IDW'(k)) begin
        op_s = i[k*FPWID +: FPWID];
      end else begin
        op_s = op_s;
      end
    end
  end

  // Ack is only raised when the capture stage can actually take the operand.
  always_comb begin
    ack = '0;
    if (take_s) begin
      ack[gnt_s] = 1'b1;
    end else begin
      ack = '0;
    end
  end

  // Capture stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r  <= 1'b0;
      s1_id_r <= '0;
      s1_op_r <= '0;
      rr_r    <= '0;
    end else begin
      if (adv1_s) begin
        s1_v_r  <= gnt_v_s;
        s1_id_r <= gnt_s;
        s1_op_r <= op_s;
      end
      if (take_s) begin
        rr_r <= wrap_inc(gnt_s);
      end
    end
  end

  // Output stage: decompose and classify the captured operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_v     <= 1'b0;
      o_id    <= '0;
      o_class <= 10'd0;
      o_sgn   <= 1'b0;
      o_exp   <= '0;
      o_fract <= '0;
    end else if (adv2_s) begin
      o_v     <= s1_v_r;
      o_id    <= s1_id_r;
      o_class <= fp_class(s1_op_r[FPWID-1], s1_exp_s, s1_man_s);
      o_sgn   <= s1_op_r[FPWID-1];
      o_exp   <= s1_exp_s;
      o_fract <= {|s1_exp_s, s1_man_s};
    end
  end

`ifdef FPCLASS_STATS_EN
  // Saturating count of consumed NaN results; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      nan_cnt <= 16'h0000;
    end else if (cnt_clr) begin
      nan_cnt <= 16'h0000;
    end else if (o_v && o_rdy && (o_class[8] || o_class[9]) && (nan_cnt != 16'hFFFF)) begin
      nan_cnt <= nan_cnt + 16'h0001;
    end
  end
`endif

endmodule
